// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared ALU definitions: opcode encoding, result record and the reference operation.
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    NOR  = 3'd2,
    OR   = 3'd3,
    NAND = 3'd4,
    AND  = 3'd5,
    XNOR = 3'd6
  } alu_op_e;

  localparam logic [ALU_OP_W-1:0] OP_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] x;
    logic                  z;
  } alu_result_t;

  // Behaviour of the SimpleAlu; ADD/SUB wrap at ALU_DATA_W, illegal codes give zero.
  function automatic alu_result_t alu_compute(input logic [ALU_DATA_W-1:0] a,
                                              input logic [ALU_DATA_W-1:0] b,
                                              input logic [ALU_OP_W-1:0]   op);
    alu_result_t r;
    r.x = '0;
    case (alu_op_e'(op))
      ADD:     r.x = a + b;
      SUB:     r.x = a - b;
      NOR:     r.x = ~(a | b);
      OR:      r.x = a | b;
      NAND:    r.x = ~(a & b);
      AND:     r.x = a & b;
      XNOR:    r.x = ~(a ^ b);
      default: r.x = '0;
    endcase
    r.z = (r.x == '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command stream, the ALU operand/result ports and the result stream.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready and m_valid/m_ready are standard valid/ready pairs.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_a;
  logic [DATA_WIDTH-1:0] s_b;
  logic [OP_WIDTH-1:0]   s_op;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_x;
  logic                  alu_z;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_x;
  logic                  m_z;

  // Sequencer side.
  modport slave (
    input  s_valid, s_a, s_b, s_op, alu_x, alu_z, m_ready,
    output s_ready, alu_a, alu_b, alu_op, m_valid, m_x, m_z
  );

  // Command source / result sink / ALU side.
  modport master (
    output s_valid, s_a, s_b, s_op, alu_x, alu_z, m_ready,
    input  s_ready, alu_a, alu_b, alu_op, m_valid, m_x, m_z
  );

endinterface

// File: rtl/alu_cmd_sequencer_result_fifo.sv
// Synchronous FIFO of ALU results; head is a direct read of the oldest entry (no bypass).
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; push and pop may coincide.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  alu_result_t push_dat,
  input  logic        pop,
  output alu_result_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  alu_result_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues A/B/OP commands to a fixed-latency ALU and returns X/Z results in issue order.
// Latency: command accept to m_valid is ALU_LATENCY+2 cycles with an empty result FIFO.
// Backpressure: credit-based; s_ready drops when in-flight plus queued results reach
// RESULT_DEPTH. Optional ALU_SEQ_CHECK_EN adds an in-line result checker (chk_err ports).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = ALU_DATA_W,
  parameter int OP_WIDTH     = ALU_OP_W,
  parameter int ALU_LATENCY  = 1,
  parameter int RESULT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_cmd_sequencer_if.slave bus,
  output logic [15:0]        illegal_cnt,
  output logic               busy
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic               chk_err,
  output logic [15:0]        chk_err_cnt
`endif
);

  localparam int CW = $clog2(RESULT_DEPTH + 1);

  logic                 rdy_en;
  logic [CW-1:0]        credits;
  logic [ALU_LATENCY:0] inflight;
  logic                 accept;
  logic                 op_legal;
  logic                 issue;
  logic                 drop;
  logic                 pop;
  logic                 capture;
  alu_result_t          cap_dat;
  alu_result_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign op_legal = (bus.s_op < OP_WIDTH'(OP_ILLEGAL));
  assign accept   = bus.s_valid & bus.s_ready;
  assign issue    = accept & op_legal;
  assign drop     = accept & ~op_legal;
  assign pop      = bus.m_valid & bus.m_ready;
  assign capture  = inflight[ALU_LATENCY];

  // rdy_en holds s_ready low during reset and for the cycle it is released in.
  always_ff @(posedge clk) begin
    if (reset) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  assign bus.s_ready = rdy_en & (credits != '0);

  // One credit per result slot: taken on legal issue, given back on result pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CW'(RESULT_DEPTH);
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // ALU input registers; they hold their value while idle or on illegal commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= '0;
    end else if (issue) begin
      bus.alu_a  <= bus.s_a;
      bus.alu_b  <= bus.s_b;
      bus.alu_op <= bus.s_op;
    end
  end

  // In-flight marker pipe; the tail bit says alu_x/alu_z carry a result this cycle.
  always_ff @(posedge clk) begin
    if (reset) inflight <= '0;
    else       inflight <= {inflight[ALU_LATENCY-1:0], issue};
  end

  // Dropped illegal-opcode commands, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (drop && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign cap_dat.x = ALU_DATA_W'(bus.alu_x);
  assign cap_dat.z = bus.alu_z;

  // Credits already prevent overflow; the full term only guards against misuse.
  alu_result_fifo #(
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (capture & ~fifo_full),
    .push_dat (cap_dat),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Result stream straight from the FIFO head, zeroed while empty.
  always_comb begin
    bus.m_valid = ~fifo_empty;
    bus.m_x     = '0;
    bus.m_z     = 1'b0;
    if (!fifo_empty) begin
      bus.m_x = head.x[DATA_WIDTH-1:0];
      bus.m_z = head.z;
    end
  end

  assign busy = (|inflight) | ~fifo_empty;

`ifdef ALU_SEQ_CHECK_EN
  alu_result_t           exp_res;
  logic [DATA_WIDTH-1:0] exp_now;
  logic [DATA_WIDTH-1:0] exp_pipe [ALU_LATENCY+1];
  logic [DATA_WIDTH-1:0] exp_tail;
  logic                  chk_mis;
  logic                  chk_unused;

  assign exp_res    = alu_compute(ALU_DATA_W'(bus.s_a), ALU_DATA_W'(bus.s_b),
                                  ALU_OP_W'(bus.s_op));
  assign exp_now    = exp_res.x[DATA_WIDTH-1:0];
  assign chk_unused = exp_res.z;
  assign exp_tail   = exp_pipe[ALU_LATENCY];
  assign chk_mis    = capture &
                      ((bus.alu_x != exp_tail) | (bus.alu_z != (exp_tail == '0)));

  // Expected X travels in lock-step with the in-flight marker.
  always_ff @(posedge clk) begin
    exp_pipe[0] <= exp_now;
    for (int i = 1; i <= ALU_LATENCY; i++) begin
      exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  // Sticky error flag and saturating mismatch count.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_err     <= 1'b0;
      chk_err_cnt <= '0;
    end else if (chk_mis) begin
      chk_err <= 1'b1;
      if (chk_err_cnt != 16'hFFFF) chk_err_cnt <= chk_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural registered ALU.
// Latency: n/a.
// Backpressure: drives fixed and random m_ready patterns.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DW    = 32;
  localparam int OW    = 3;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] ex;
    logic        ez;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] illegal_cnt;
  logic        busy;
`ifdef ALU_SEQ_CHECK_EN
  logic        chk_err;
  logic [15:0] chk_err_cnt;
`endif

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_cmd_sequencer #(
    .DATA_WIDTH   (DW),
    .OP_WIDTH     (OW),
    .ALU_LATENCY  (LAT),
    .RESULT_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .illegal_cnt (illegal_cnt),
    .busy        (busy)
`ifdef ALU_SEQ_CHECK_EN
    ,
    .chk_err     (chk_err),
    .chk_err_cnt (chk_err_cnt)
`endif
  );

  // ALU stand-in: registered inputs, result valid LAT cycles after the sampling edge.
  alu_result_t alu_now;
  alu_result_t alu_pipe [LAT];
  assign alu_now = alu_compute(bus.alu_a, bus.alu_b, bus.alu_op);
  always @(posedge clk) begin
    alu_pipe[0] <= alu_now;
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_x = alu_pipe[LAT-1].x;
  assign bus.alu_z = alu_pipe[LAT-1].z;

  int          checks = 0;
  int          failures = 0;
  int          results = 0;
  int          cyc = 0;
  int          exp_illegal = 0;
  logic        rand_bp = 1'b0;
  logic        mv_seen = 1'b0;
  alu_result_t exp_q [$];
  vec_t        vecs [9];

  function automatic logic [31:0] tb_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~(a | b);
      3'd3:    return a | b;
      3'd4:    return ~(a & b);
      3'd5:    return a & b;
      3'd6:    return ~(a ^ b);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge (handshake + result scoreboard), return 1ns after posedge.
  task automatic tick(output logic hs);
    alu_result_t e;
    @(negedge clk);
    hs      = bus.s_valid & bus.s_ready;
    mv_seen = bus.m_valid;
    if (!reset && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got x=0x%08h z=%0b required no result", bus.m_x, bus.m_z);
      end else begin
        e = exp_q.pop_front();
        check("result_x", bus.m_x, e.x);
        check("result_z", 32'(bus.m_z), 32'(e.z));
        results++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_bp) bus.m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step(input int n);
    logic hs;
    repeat (n) tick(hs);
  endtask

  // Present one command until accepted or budget expires; queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] ex, input logic ez, input int budget,
                      output logic ok);
    logic        hs;
    alu_result_t r;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_op    = op;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(hs);
      if (hs) ok = 1'b1;
    end
    bus.s_valid = 1'b0;
    if (ok && op != 3'd7) begin
      r.x = ex;
      r.z = ez;
      exp_q.push_back(r);
    end
    if (ok && op == 3'd7) exp_illegal++;
  endtask

  task automatic send_chk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] ex, input logic ez);
    logic ok;
    send(a, b, op, ex, ez, 40, ok);
    check("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else step(1);
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    logic ok;
    int   lat, first_cyc, last_cyc, base;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    vecs[0] = '{32'h00000005, 32'h00000003, 3'd0, 32'h00000008, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h12345678, 32'h12345678, 3'd1, 32'h00000000, 1'b1};
    vecs[3] = '{32'h00000000, 32'h00000001, 3'd1, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000000, 3'd2, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{32'hF0F00000, 32'h00000F0F, 3'd3, 32'hF0F00F0F, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 32'h00000000, 1'b1};
    vecs[7] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 3'd5, 32'h05050505, 1'b0};
    vecs[8] = '{32'h00000000, 32'hFFFFFFFF, 3'd6, 32'h00000000, 1'b1};

    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_op    = '0;
    bus.m_ready = 1'b1;
    step(3);

    // Reset state.
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_x", bus.m_x, 32'd0);
    check("rst_m_z", 32'(bus.m_z), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(1);
    check("s_ready_after_reset", 32'(bus.s_ready), 32'd1);

    // Single ADD: latency and value.
    send_chk(32'h5, 32'h3, 3'd0, 32'h8, 1'b0);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      step(1);
      if (mv_seen) lat = k;
    end
    check("cmd_to_m_valid_latency", 32'(lat), 32'(LAT + 2));
    drain("drain_single");

    // Table of all opcodes back-to-back; one accept per cycle expected.
    base = results;
    first_cyc = 0;
    last_cyc = 0;
    foreach (vecs[i]) begin
      send_chk(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ex, vecs[i].ez);
      if (i == 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    check("b2b_accept_span", 32'(last_cyc - first_cyc), 32'd8);
    drain("drain_table");
    check("table_result_count", 32'(results - base), 32'd9);

    // Backpressure: only RESULT_DEPTH commands fit while m_ready is low.
    base = results;
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(32'(i * 257), 32'(i), 3'd0, 32'(i * 258), 1'b0, 3, ok);
      check("bp_accept", 32'(ok), 32'd1);
    end
    step(2);
    check("bp_s_ready_low", 32'(bus.s_ready), 32'd0);
    send(32'(5 * 257), 32'd5, 3'd0, 32'(5 * 258), 1'b0, 6, ok);
    check("bp_fifth_blocked", 32'(ok), 32'd0);
    check("bp_no_result_while_stalled", 32'(results - base), 32'd0);
    bus.m_ready = 1'b1;
    send_chk(32'(5 * 257), 32'd5, 3'd0, 32'(5 * 258), 1'b0);
    send_chk(32'(6 * 257), 32'd6, 3'd0, 32'(6 * 258), 1'b0);
    drain("drain_bp");
    check("bp_result_count", 32'(results - base), 32'd6);

    // Illegal opcode between two ADDs.
    base = results;
    send_chk(32'h11, 32'h22, 3'd0, 32'h33, 1'b0);
    send_chk(32'hDEAD, 32'hBEEF, 3'd7, 32'h0, 1'b0);
    step(1);
    check("illegal_alu_a_held", bus.alu_a, 32'h11);
    check("illegal_alu_b_held", bus.alu_b, 32'h22);
    check("illegal_alu_op_held", 32'(bus.alu_op), 32'd0);
    check("illegal_cnt_one", 32'(illegal_cnt), 32'd1);
    send_chk(32'h40, 32'h2, 3'd0, 32'h42, 1'b0);
    drain("drain_illegal");
    check("illegal_result_count", 32'(results - base), 32'd2);

    // Reset with three operations outstanding.
    bus.m_ready = 1'b0;
    send_chk(32'h1, 32'h1, 3'd0, 32'h2, 1'b0);
    send_chk(32'h2, 32'h2, 3'd0, 32'h4, 1'b0);
    send_chk(32'h3, 32'h3, 3'd0, 32'h6, 1'b0);
    reset = 1'b1;
    step(2);
    exp_q.delete();
    exp_illegal = 0;
    reset = 1'b0;
    step(1);
    bus.m_ready = 1'b1;
    base = results;
    step(6);
    check("mid_reset_no_results", 32'(results - base), 32'd0);
    check("mid_reset_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_illegal_cnt", 32'(illegal_cnt), 32'd0);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'(i), 32'h100, 3'd3, 32'(i) | 32'h100, 1'b0, 1, ok);
      check("credits_restored_accept", 32'(ok), 32'd1);
    end
    bus.m_ready = 1'b1;
    drain("drain_after_reset");

    // Random traffic with random result backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      rop = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      send(ra, rb, rop, tb_ref(ra, rb, rop), (tb_ref(ra, rb, rop) == 32'h0), 60, ok);
      check("rand_accept", 32'(ok), 32'd1);
      if ($urandom_range(0, 3) == 0) step(1);
    end
    rand_bp = 1'b0;
    bus.m_ready = 1'b1;
    drain("drain_random");
    check("rand_illegal_cnt", 32'(illegal_cnt), 32'(exp_illegal));
`ifdef ALU_SEQ_CHECK_EN
    check("chk_err_clear", 32'(chk_err), 32'd0);
    check("chk_err_cnt_zero", 32'(chk_err_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the SimpleAlu operand/result interface.
- Accepts ALU commands (A, B, OP) over a valid/ready stream and drives them onto the ALU's registered input ports.
- Tracks in-flight operations across the fixed ALU latency, captures X/Z into a result FIFO, and returns them over a valid/ready stream in issue order.
- Sits between a command source (CPU/DMA/test engine) and a SimpleAlu instance.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- OP_WIDTH, 3, opcode width; codes 0..6 legal (ADD, SUB, NOR, OR, NAND, AND, XNOR), 7 illegal.
- ALU_LATENCY, 1, clocks from ALU input sample to valid X/Z; range 1..8.
- RESULT_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  command valid.
- s_ready  out  1  command ready.
- s_a  in  DATA_WIDTH  operand A.
- s_b  in  DATA_WIDTH  operand B.
- s_op  in  OP_WIDTH  opcode.
- alu_a  out  DATA_WIDTH  to ALU A.
- alu_b  out  DATA_WIDTH  to ALU B.
- alu_op  out  OP_WIDTH  to ALU OP.
- alu_x  in  DATA_WIDTH  from ALU X.
- alu_z  in  1  from ALU Z.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- m_x  out  DATA_WIDTH  result value.
- m_z  out  1  zero flag.
- illegal_cnt  out  16  count of dropped illegal-opcode commands; saturates at 0xFFFF.
- busy  out  1  high when any operation is in flight or the result FIFO is non-empty.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Outputs: s_ready=0, m_valid=0, m_x=0, m_z=0, alu_a=0, alu_b=0, alu_op=0, illegal_cnt=0, busy=0.
  - Internal state: in-flight pipe cleared, FIFO emptied, credits=RESULT_DEPTH.
  - A reset asserted mid-operation discards all in-flight and queued results; nothing is emitted for them.
  - s_ready rises the first cycle after reset deasserts.
- Credits:
  - s_ready = (credits != 0).
  - A credit is reserved on every legal accept (s_valid & s_ready & s_op<=6).
  - A credit is returned on every result pop (m_valid & m_ready).
  - Reserve and return in the same cycle leave credits unchanged.
  - Credits therefore never allow in-flight plus stored results to exceed RESULT_DEPTH, so the FIFO cannot overflow.
- Issue:
  - On a legal accept, register s_a/s_b/s_op onto alu_a/alu_b/alu_op in the same edge.
  - Shift a 1 into the in-flight pipe of length ALU_LATENCY+1; otherwise shift a 0.
  - alu_* hold their last value when idle.
  - Back-to-back accepts are supported, one per cycle.
- Illegal opcode: a command accepted with s_op=7 is consumed (handshake completes), not issued to the ALU, reserves no credit, and increments illegal_cnt.
- Capture:
  - When the pipe tail bit is 1, alu_x/alu_z are written into the FIFO that cycle.
  - Total command-to-m_valid latency with an empty FIFO is ALU_LATENCY+2 cycles.
- Output: m_x/m_z/m_valid come from the FIFO head. A pop and a push in the same cycle are both honoured; with the FIFO empty, no bypass is allowed.
- Ordering: results emerge strictly in issue order.
- Throughput: 1 result/cycle in steady state with m_ready held high.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined:
  - An internal reference model computes the expected X per issued command, using DATA_WIDTH wrap-around arithmetic for ADD/SUB.
  - The expected value travels down the pipe alongside the command.
  - At capture it is compared with alu_x, and alu_z is checked against (expected==0).
  - Adds output port chk_err (1 bit, sticky, cleared only by reset) plus chk_err_cnt (16 bits, saturating).
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (ADD=0, SUB=1, NOR=2, OR=3, NAND=4, AND=5, XNOR=6).
  - OP_ILLEGAL=7.
  - Default width constants.
  - alu_result_t struct {x, z}.
  - Function alu_compute(a, b, op), shared by the check feature and benches.
- Sub-module alu_result_fifo: synchronous FIFO of alu_result_t, depth RESULT_DEPTH, with push/pop/full/empty.

Test Plan:
- Reset then a single command A=0x00000005, B=0x00000003, OP=ADD with m_ready=1 -> m_valid after ALU_LATENCY+2 cycles, m_x=0x00000008, m_z=0.
- A=0xFFFFFFFF, B=0x00000001, OP=ADD, followed by A=0x12345678, B=0x12345678, OP=SUB -> results 0x00000000 with Z=1, then 0x00000000 with Z=1, in order.
- m_ready=0 while 6 back-to-back commands are offered (RESULT_DEPTH=4) -> exactly 4 accepted, s_ready=0 afterwards; releasing m_ready drains 4 results and then accepts the remaining 2.
- Command with OP=7 between two ADDs -> ALU not driven for it, illegal_cnt=1, exactly 2 results emitted.
- Reset pulsed while 3 operations are in flight -> no m_valid afterwards, busy=0, credits restored (4 commands accepted back-to-back next).
- Random 100000 commands with random m_ready backpressure and ALU_SEQ_CHECK_EN defined -> all results match alu_compute and chk_err stays 0.
